// File: rtl/seq_pingpong_loader_pkg.sv
// Shared constants, state type and small helpers for the ping-pong sequence
// loader. Every file of the block imports this package, so the letter width,
// the beat width and the maximum sequence length are set in one place.
package seq_pingpong_loader_pkg;

  localparam int LETTER_WIDTH     = 2;
  localparam int LETTERS_PER_BEAT = 4;
  localparam int MAX_SEQ_LEN      = 32;
  localparam int LEN_W            = $clog2(MAX_SEQ_LEN + 1);
  localparam int MAX_BEATS        = MAX_SEQ_LEN / LETTERS_PER_BEAT;
  localparam int BEAT_CNT_W       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int LETTER_IDX_W     = $clog2(MAX_SEQ_LEN);
  localparam int BEAT_W           = LETTERS_PER_BEAT * LETTER_WIDTH;
  localparam int SEQ_W            = MAX_SEQ_LEN * LETTER_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

  // A length is usable when it names at least one letter and fits the arrays.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (int'(len) <= MAX_SEQ_LEN);
  endfunction

  // Index of the last beat of a job: ceil(max(q,d)/LPB) - 1.
  // Only called with legal lengths, so longest is never zero.
  function automatic logic [BEAT_CNT_W-1:0] last_beat_idx(
    input logic [LEN_W-1:0] q_len,
    input logic [LEN_W-1:0] d_len
  );
    int longest;
    longest = (q_len > d_len) ? int'(q_len) : int'(d_len);
    return BEAT_CNT_W'((longest - 1) / LETTERS_PER_BEAT);
  endfunction

endpackage

// File: rtl/seq_pingpong_loader_seq_bank.sv
// One storage bank of the ping-pong loader: query and database letter arrays,
// both lengths and the "holds a complete job" flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i             new job claims this bank: latch lengths, clear arrays
//   query_len_i         query length to latch on start_i
//   database_len_i      database length to latch on start_i
//   wr_en_i             write one beat of letters at beat_idx_i
//   beat_idx_i          beat number within the job
//   query_beat_i        query letters of the beat, letter 0 in LSBs
//   database_beat_i     database letters of the beat, letter 0 in LSBs
//   set_full_i          final beat written; job is complete
//   release_i           consumer done with this bank
//   full_o              bank holds a complete job
//   query_seq_o         stored query letters, index i = letter i
//   database_seq_o      stored database letters
//   query_len_o         stored query length
//   database_len_o      stored database length
module seq_bank
  import seq_pingpong_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      query_len_i,
  input  logic [LEN_W-1:0]      database_len_i,
  input  logic                  wr_en_i,
  input  logic [BEAT_CNT_W-1:0] beat_idx_i,
  input  logic [BEAT_W-1:0]     query_beat_i,
  input  logic [BEAT_W-1:0]     database_beat_i,
  input  logic                  set_full_i,
  input  logic                  release_i,
  output logic                  full_o,
  output logic [SEQ_W-1:0]      query_seq_o,
  output logic [SEQ_W-1:0]      database_seq_o,
  output logic [LEN_W-1:0]      query_len_o,
  output logic [LEN_W-1:0]      database_len_o
);

  logic [MAX_SEQ_LEN-1:0][LETTER_WIDTH-1:0] query_seq_q, query_seq_d;
  logic [MAX_SEQ_LEN-1:0][LETTER_WIDTH-1:0] database_seq_q, database_seq_d;
  logic [LEN_W-1:0]                         query_len_q, query_len_d;
  logic [LEN_W-1:0]                         database_len_q, database_len_d;
  logic                                     full_q, full_d;
  logic [LETTER_IDX_W-1:0]                  letter_idx;

  always_comb begin
    query_seq_d    = query_seq_q;
    database_seq_d = database_seq_q;
    query_len_d    = query_len_q;
    database_len_d = database_len_q;
    full_d         = full_q;
    letter_idx     = '0;

    // Clearing on start means letters beyond the last beat never carry a
    // previous job's data into the new one.
    if (start_i) begin
      query_seq_d    = '0;
      database_seq_d = '0;
      query_len_d    = query_len_i;
      database_len_d = database_len_i;
    end else if (wr_en_i) begin
      for (int j = 0; j < LETTERS_PER_BEAT; j++) begin
        letter_idx = IDX_BASE(beat_idx_i) + LETTER_IDX_W'(j);
        // The shorter lane pads with zeros; each lane is masked by its own length.
        if (LEN_W'(letter_idx) < query_len_q) begin
          query_seq_d[letter_idx] = query_beat_i[j*LETTER_WIDTH +: LETTER_WIDTH];
        end else begin
          query_seq_d[letter_idx] = '0;
        end
        if (LEN_W'(letter_idx) < database_len_q) begin
          database_seq_d[letter_idx] = database_beat_i[j*LETTER_WIDTH +: LETTER_WIDTH];
        end else begin
          database_seq_d[letter_idx] = '0;
        end
      end
    end

    if (set_full_i) begin
      full_d = 1'b1;
    end else if (release_i) begin
      full_d = 1'b0;
    end
  end

  function automatic logic [LETTER_IDX_W-1:0] IDX_BASE(input logic [BEAT_CNT_W-1:0] beat);
    return LETTER_IDX_W'(beat) * LETTER_IDX_W'(LETTERS_PER_BEAT);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      query_seq_q    <= '0;
      database_seq_q <= '0;
      query_len_q    <= '0;
      database_len_q <= '0;
      full_q         <= 1'b0;
    end else begin
      query_seq_q    <= query_seq_d;
      database_seq_q <= database_seq_d;
      query_len_q    <= query_len_d;
      database_len_q <= database_len_d;
      full_q         <= full_d;
    end
  end

  assign full_o         = full_q;
  assign query_seq_o    = query_seq_q;
  assign database_seq_o = database_seq_q;
  assign query_len_o    = query_len_q;
  assign database_len_o = database_len_q;

endmodule

// File: rtl/seq_pingpong_loader.sv
// Double-buffered loader for query/database letter sequences. Accepts a job
// request with both lengths, then unpacks handshaked multi-letter beats into
// one of two banks while the other bank is presented to the consumer.
//
// state | meaning
// IDLE  | waiting for a job request; accepts one when a bank is free
// LOAD  | receiving beats into bank wr_bank until the final beat
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   load_start          job request pulse, samples query_len/database_len
//   query_len           query letter count, 1..MAX_SEQ_LEN
//   database_len        database letter count, 1..MAX_SEQ_LEN
//   load_ready          a job request is accepted this cycle
//   len_err             one-cycle pulse after a request with an illegal length
//   in_valid, in_ready  beat handshake
//   query_in            query letters of a beat, letter 0 in LSBs
//   database_in         database letters of a beat, letter 0 in LSBs
//   job_valid           the presented bank holds a complete job
//   job_release         consumer finished with the presented job
//   query_seq_out       presented query letters, index i = letter i
//   database_seq_out    presented database letters
//   query_len_out       presented query length
//   database_len_out    presented database length
module seq_pingpong_loader
  import seq_pingpong_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [LEN_W-1:0]   query_len,
  input  logic [LEN_W-1:0]   database_len,
  output logic               load_ready,
  output logic               len_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BEAT_W-1:0]  query_in,
  input  logic [BEAT_W-1:0]  database_in,
  output logic               job_valid,
  input  logic               job_release,
  output logic [SEQ_W-1:0]   query_seq_out,
  output logic [SEQ_W-1:0]   database_seq_out,
  output logic [LEN_W-1:0]   query_len_out,
  output logic [LEN_W-1:0]   database_len_out
);

  loader_state_t         state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_cnt_q, full_cnt_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0] last_beat_q, last_beat_d;
  logic                  len_err_q, len_err_d;

  logic                  lens_ok;
  logic                  accept;
  logic                  reject;
  logic                  beat_fire;
  logic                  final_beat;
  logic                  release_fire;

  logic [1:0]            bank_full;
  logic [SEQ_W-1:0]      bank_qseq [2];
  logic [SEQ_W-1:0]      bank_dseq [2];
  logic [LEN_W-1:0]      bank_qlen [2];
  logic [LEN_W-1:0]      bank_dlen [2];

  assign load_ready   = (state_q == IDLE) && (full_cnt_q < 2'd2);
  assign in_ready     = (state_q == LOAD);
  assign lens_ok      = len_legal(query_len) && len_legal(database_len);
  assign accept       = load_start && load_ready && lens_ok;
  assign reject       = load_start && load_ready && !lens_ok;
  assign beat_fire    = in_valid && in_ready;
  assign final_beat   = beat_fire && (beat_cnt_q == last_beat_q);
  assign job_valid    = bank_full[rd_bank_q];
  assign release_fire = job_release && job_valid;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    beat_cnt_d  = beat_cnt_q;
    last_beat_d = last_beat_q;
    len_err_d   = reject;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = LOAD;
          beat_cnt_d  = '0;
          last_beat_d = last_beat_idx(query_len, database_len);
        end
      end
      LOAD: begin
        if (final_beat) begin
          state_d   = IDLE;
          wr_bank_d = ~wr_bank_q;
        end else if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_bank_d = release_fire ? ~rd_bank_q : rd_bank_q;

    // A completion and a release in the same cycle cancel out.
    case ({final_beat, release_fire})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_cnt_q  <= 2'd0;
      beat_cnt_q  <= '0;
      last_beat_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_cnt_q  <= full_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      last_beat_q <= last_beat_d;
      len_err_q   <= len_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    seq_bank u_bank (
      .clk             (clk),
      .rst             (rst),
      .start_i         (accept && (wr_bank_q == 1'(b))),
      .query_len_i     (query_len),
      .database_len_i  (database_len),
      .wr_en_i         (beat_fire && (wr_bank_q == 1'(b))),
      .beat_idx_i      (beat_cnt_q),
      .query_beat_i    (query_in),
      .database_beat_i (database_in),
      .set_full_i      (final_beat && (wr_bank_q == 1'(b))),
      .release_i       (release_fire && (rd_bank_q == 1'(b))),
      .full_o          (bank_full[b]),
      .query_seq_o     (bank_qseq[b]),
      .database_seq_o  (bank_dseq[b]),
      .query_len_o     (bank_qlen[b]),
      .database_len_o  (bank_dlen[b])
    );
  end

  assign len_err          = len_err_q;
  assign query_seq_out    = bank_qseq[rd_bank_q];
  assign database_seq_out = bank_dseq[rd_bank_q];
  assign query_len_out    = bank_qlen[rd_bank_q];
  assign database_len_out = bank_dlen[rd_bank_q];

endmodule

// File: tb/tb_seq_pingpong_loader.sv
module tb_seq_pingpong_loader;
  import seq_pingpong_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [LEN_W-1:0]  query_len;
  logic [LEN_W-1:0]  database_len;
  logic              load_ready;
  logic              len_err;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] query_in;
  logic [BEAT_W-1:0] database_in;
  logic              job_valid;
  logic              job_release;
  logic [SEQ_W-1:0]  query_seq_out;
  logic [SEQ_W-1:0]  database_seq_out;
  logic [LEN_W-1:0]  query_len_out;
  logic [LEN_W-1:0]  database_len_out;

  always #5 clk = ~clk;

  seq_pingpong_loader dut (
    .clk              (clk),
    .rst              (rst),
    .load_start       (load_start),
    .query_len        (query_len),
    .database_len     (database_len),
    .load_ready       (load_ready),
    .len_err          (len_err),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .query_in         (query_in),
    .database_in      (database_in),
    .job_valid        (job_valid),
    .job_release      (job_release),
    .query_seq_out    (query_seq_out),
    .database_seq_out (database_seq_out),
    .query_len_out    (query_len_out),
    .database_len_out (database_len_out)
  );

  // Model: queue of complete jobs in load order; the head is what must be presented.
  typedef struct {
    int               qlen;
    int               dlen;
    logic [SEQ_W-1:0] qseq;
    logic [SEQ_W-1:0] dseq;
  } job_t;

  job_t model_q[$];
  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;
  logic [LETTER_WIDTH-1:0] raw_q [MAX_SEQ_LEN];
  logic [LETTER_WIDTH-1:0] raw_d [MAX_SEQ_LEN];

  task automatic chk(input string name, input logic [SEQ_W-1:0] act, input logic [SEQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_job_valid", SEQ_W'(job_valid), SEQ_W'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        chk("model_query_len", SEQ_W'(query_len_out), SEQ_W'(model_q[0].qlen));
        chk("model_db_len", SEQ_W'(database_len_out), SEQ_W'(model_q[0].dlen));
        chk("model_query_seq", query_seq_out, model_q[0].qseq);
        chk("model_db_seq", database_seq_out, model_q[0].dseq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fill=0: random letters; fill=1: every letter 3 (exposes missing padding).
  task automatic load_job(input int qlen, input int dlen, input int fill, input bit rel_on_final);
    job_t j;
    int   nb;
    for (int i = 0; i < MAX_SEQ_LEN; i++) begin
      raw_q[i] = (fill != 0) ? 2'b11 : LETTER_WIDTH'($urandom);
      raw_d[i] = (fill != 0) ? 2'b11 : LETTER_WIDTH'($urandom);
    end
    j.qlen = qlen;
    j.dlen = dlen;
    j.qseq = '0;
    j.dseq = '0;
    for (int i = 0; i < qlen; i++) j.qseq[i*LETTER_WIDTH +: LETTER_WIDTH] = raw_q[i];
    for (int i = 0; i < dlen; i++) j.dseq[i*LETTER_WIDTH +: LETTER_WIDTH] = raw_d[i];

    load_start   = 1'b1;
    query_len    = LEN_W'(qlen);
    database_len = LEN_W'(dlen);
    tick();
    load_start = 1'b0;
    chk("in_ready_after_accept", SEQ_W'(in_ready), 1);

    nb = ((qlen > dlen ? qlen : dlen) + LETTERS_PER_BEAT - 1) / LETTERS_PER_BEAT;
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      for (int l = 0; l < LETTERS_PER_BEAT; l++) begin
        query_in[l*LETTER_WIDTH +: LETTER_WIDTH]    = raw_q[k*LETTERS_PER_BEAT + l];
        database_in[l*LETTER_WIDTH +: LETTER_WIDTH] = raw_d[k*LETTERS_PER_BEAT + l];
      end
      job_release = rel_on_final && (k == nb - 1);
      tick();
      if (k == nb - 1) begin
        if (job_release && model_q.size() > 0) void'(model_q.pop_front());
        model_q.push_back(j);
      end
      in_valid    = 1'b0;
      job_release = 1'b0;
      if (k == 0 && nb >= 3) tick();
    end
    query_in    = '0;
    database_in = '0;
  endtask

  task automatic release_job();
    job_release = 1'b1;
    tick();
    job_release = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, SEQ_W'(load_ready), 1);
    chk({tag, "_in_ready"}, SEQ_W'(in_ready), 0);
    chk({tag, "_len_err"}, SEQ_W'(len_err), 0);
    chk({tag, "_job_valid"}, SEQ_W'(job_valid), 0);
    chk({tag, "_query_seq"}, query_seq_out, 0);
    chk({tag, "_db_seq"}, database_seq_out, 0);
    chk({tag, "_query_len"}, SEQ_W'(query_len_out), 0);
    chk({tag, "_db_len"}, SEQ_W'(database_len_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    query_len    = '0;
    database_len = '0;
    in_valid     = 1'b0;
    query_in     = '0;
    database_in  = '0;
    job_release  = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_en = 1'b1;

    // Single 8/8 job, two beats.
    load_job(8, 8, 0, 1'b0);
    chk("t1_job_valid", SEQ_W'(job_valid), 1);
    chk("t1_qlen", SEQ_W'(query_len_out), 8);
    chk("t1_dlen", SEQ_W'(database_len_out), 8);
    release_job();
    chk("t1_released", SEQ_W'(job_valid), 0);

    // 5/11 with all-ones letters: padding must zero query letters 5..31.
    load_job(5, 11, 1, 1'b0);
    chk("t2_qseq", query_seq_out, 64'h3FF);
    chk("t2_dseq", database_seq_out, 64'h3FFFFF);
    chk("t2_qlen", SEQ_W'(query_len_out), 5);
    chk("t2_dlen", SEQ_W'(database_len_out), 11);
    release_job();

    // Two jobs back to back; third request ignored while both banks full.
    load_job(32, 32, 0, 1'b0);
    chk("t3_ready_one_full", SEQ_W'(load_ready), 1);
    load_job(3, 17, 0, 1'b0);
    chk("t3_ready_two_full", SEQ_W'(load_ready), 0);
    load_start   = 1'b1;
    query_len    = LEN_W'(4);
    database_len = LEN_W'(4);
    tick();
    load_start = 1'b0;
    chk("t3_ignored_in_ready", SEQ_W'(in_ready), 0);
    chk("t3_ignored_len_err", SEQ_W'(len_err), 0);
    chk("t3_presented_qlen", SEQ_W'(query_len_out), 32);
    release_job();
    chk("t3_after_rel_ready", SEQ_W'(load_ready), 1);
    chk("t3_after_rel_valid", SEQ_W'(job_valid), 1);
    chk("t3_after_rel_qlen", SEQ_W'(query_len_out), 3);

    // Final beat of a new job coincides with release of the presented one.
    load_job(12, 7, 0, 1'b1);
    chk("t4_valid", SEQ_W'(job_valid), 1);
    chk("t4_ready", SEQ_W'(load_ready), 1);
    chk("t4_qlen", SEQ_W'(query_len_out), 12);
    chk("t4_dlen", SEQ_W'(database_len_out), 7);
    load_job(1, 1, 0, 1'b0);
    chk("t4_two_full", SEQ_W'(load_ready), 0);
    release_job();
    chk("t4_next_qlen", SEQ_W'(query_len_out), 1);
    release_job();
    chk("t4_empty_valid", SEQ_W'(job_valid), 0);
    chk("t4_empty_ready", SEQ_W'(load_ready), 1);

    // Illegal lengths.
    load_start   = 1'b1;
    query_len    = LEN_W'(0);
    database_len = LEN_W'(4);
    tick();
    load_start = 1'b0;
    chk("t5_q0_len_err", SEQ_W'(len_err), 1);
    chk("t5_q0_in_ready", SEQ_W'(in_ready), 0);
    tick();
    chk("t5_q0_pulse_end", SEQ_W'(len_err), 0);
    chk("t5_q0_idle", SEQ_W'(load_ready), 1);
    load_start   = 1'b1;
    query_len    = LEN_W'(4);
    database_len = LEN_W'(33);
    tick();
    load_start = 1'b0;
    chk("t5_d33_len_err", SEQ_W'(len_err), 1);
    chk("t5_d33_in_ready", SEQ_W'(in_ready), 0);
    tick();
    chk("t5_d33_pulse_end", SEQ_W'(len_err), 0);

    // Reset in the middle of a 4-beat load with another job held.
    load_job(2, 2, 0, 1'b0);
    load_start   = 1'b1;
    query_len    = LEN_W'(16);
    database_len = LEN_W'(16);
    tick();
    load_start  = 1'b0;
    in_valid    = 1'b1;
    query_in    = BEAT_W'($urandom);
    database_in = BEAT_W'($urandom);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    model_q.delete();
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    tick();
    load_job(4, 3, 0, 1'b0);
    chk("t6_fresh_valid", SEQ_W'(job_valid), 1);
    chk("t6_fresh_qlen", SEQ_W'(query_len_out), 4);
    chk("t6_fresh_dlen", SEQ_W'(database_len_out), 3);
    release_job();
    tick();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pingpong_loader.md
# seq_pingpong_loader

Parametrised, double-buffered successor to the single-shot sequence buffer. It accepts variable-length query and database sequences as handshaked multi-letter beats and unpacks them into letter arrays. It holds up to two complete jobs so the next pair loads while the matrix calculation consumes the current one. It sits between the design inputs and the controller/matrix-calculation/traceback consumers.

## Interface
- LETTER_WIDTH, 2, bits per letter
- LETTERS_PER_BEAT, 4, letters carried per input beat on each sequence lane
- MAX_SEQ_LEN, 32, maximum letters per sequence (multiple of LETTERS_PER_BEAT)
- LEN_W, $clog2(MAX_SEQ_LEN+1), length field width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  job request pulse; samples query_len/database_len
- query_len  in  LEN_W  query letter count, legal range 1..MAX_SEQ_LEN
- database_len  in  LEN_W  database letter count, legal range 1..MAX_SEQ_LEN
- load_ready  out  1  job request will be accepted this cycle
- len_err  out  1  one-cycle pulse: request rejected for illegal length
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- query_in  in  LETTERS_PER_BEAT*LETTER_WIDTH  query letters; letter 0 in LSBs
- database_in  in  LETTERS_PER_BEAT*LETTER_WIDTH  database letters; letter 0 in LSBs
- job_valid  out  1  an output bank holds a complete job
- job_release  in  1  consumer finished with the presented job
- query_seq_out  out  MAX_SEQ_LEN*LETTER_WIDTH  presented query; index i = letter i
- database_seq_out  out  MAX_SEQ_LEN*LETTER_WIDTH  presented database
- query_len_out, database_len_out  out  LEN_W  lengths of the presented job

## Operation
- Two banks. Each bank holds both letter arrays, both lengths and a full flag. Pointers wr_bank and rd_bank are 1 bit each. full_cnt ranges 0..2.
- FSM IDLE/LOAD:
  - IDLE: load_ready = (full_cnt<2).
  - load_start & load_ready with both lengths legal: latch the lengths into bank wr_bank, clear beat_cnt, go to LOAD.
  - Illegal length (0 or >MAX_SEQ_LEN): pulse len_err next cycle and stay in IDLE.
  - load_start while load_ready=0 is ignored, with no error.
- LOAD: in_ready=1. Beats needed = ceil(max(query_len,database_len)/LETTERS_PER_BEAT).
  - Beat k writes letters k*LPB..k*LPB+LPB-1 of both arrays.
  - Letters at index ≥ a lane's own length are written as 0. The consumer uses the length outputs and ignores those letters.
  - On the final beat: set bank full, toggle wr_bank, increment full_cnt, return to IDLE.
- load_start during LOAD is ignored.
- in_valid outside LOAD is ignored (in_ready=0).
- job_valid = full flag of rd_bank. Outputs always show rd_bank contents.
- job_release while job_valid=1: clear the full flag, toggle rd_bank, decrement full_cnt.
- job_release while job_valid=0 is ignored.
- Final beat and release in the same cycle: full_cnt is unchanged, both flags update, and both pointers toggle.

## Timing
- Reset values:
  - outputs: load_ready=1, in_ready=0, len_err=0, job_valid=0, all seq/len outputs 0
  - internal: full flags 0, both pointers 0, state IDLE
- Reset mid-LOAD discards the partial job.
- Job acceptance: in_ready=1 in the cycle after the accepted load_start.
- Load latency: job_valid rises the cycle after the final beat if the bank was empty. Otherwise it rises the cycle after the release of the preceding job.
- Release: the next job is presented the cycle after job_release. job_valid falls the cycle after release if no other bank is full.
- A new load_start is accepted the cycle after a final beat, provided full_cnt<2 at that point (a release in the same cycle counts).
- All outputs are registered or decoded from registered state. There are no combinational in→out paths except load_ready/in_ready depending on state.

## Structure
- Shared package: LETTER_WIDTH, LETTERS_PER_BEAT, MAX_SEQ_LEN, LEN_W, BEAT_CNT_W, and the loader_state_t enum {IDLE, LOAD}.
- Sub-module seq_bank: one bank's storage plus its full flag. It is instantiated twice, with write enable, beat index and release inputs.
- The top of the block holds the FSM, pointers and full_cnt.

## Test plan
- Single job, q_len=d_len=8, LPB=4: 2 beats → job_valid=1 one cycle after the 2nd beat; letters and lengths 8/8 match.
- q_len=5, d_len=11: 3 beats → query letters 5..31 = 0; query_len_out=5, database_len_out=11.
- Two jobs back-to-back without release: both load → load_ready=0 and third load_start ignored. Release → job 2 presented next cycle, load_ready=1.
- Final beat of job 2 coincides with job_release of job 1 → full_cnt stays 1, job 2 presented next cycle, no data corruption.
- query_len=0 and, separately, database_len=33 → len_err pulse, in_ready stays 0, state IDLE.
- rst asserted after the 1st of 4 beats → all outputs at reset values next cycle; a fresh 1-beat job then loads correctly into bank 0.
